mast_frame_ctrl: RTL and testbench
==================================

// Module: mast_frame_ctrl
// PURPOSE
//  I2C master frame sequencer: one single-byte transaction per request.
//  Frame: START, 7-bit address + R/W, slave ACK, one data byte, ACK slot, STOP.
//  Generates SCL and drives the master's 4:1 frame mux, RX demux and ACK/NACK mux.
//  Reports the read byte, completion, and a NACK error to the host logic.
// PARAMETERS
//  CLK_DIV   4   clk cycles per SCL half-period; one bit = 2*CLK_DIV clocks; legal range >=2
// PORTS
//  master_clk          in   1  system clock, rising edge
//  master_rst_n        in   1  asynchronous active-low reset
//  master_start        in   1  one-cycle request; sampled only in IDLE
//  master_rw           in   1  0 = write, 1 = read; latched with master_start
//  master_addr         in   7  slave address; latched with master_start
//  master_wdata        in   8  write byte; latched with master_start
//  master_last         in   1  read only: 1 = send NACK, 0 = send ACK; latched with master_start
//  master_ack          in   1  slave ACK bit from demux (0 = ACK)
//  master_slavedata    in   1  slave data bit from demux
//  master_scl          out  1  SCL to the bus
//  master_sda_en       out  1  1 = drive SDA from mux output; 0 = release SDA
//  master_mux_select   out  2  frame mux select: 00 = zero, 01 = addr, 10 = data, 11 = ack
//  master_addrslave    out  1  current address/RW bit, MSB first
//  master_dataslave    out  1  current write-data bit, MSB first
//  master_demux_select out  1  0 = route SDA to master_ack; 1 = route SDA to master_slavedata
//  master_ack_sel      out  1  1 = master sends ACK; 0 = master sends NACK
//  master_rdata        out  8  read byte; valid when master_done pulses
//  master_busy         out  1  high from the cycle after accept until DONE
//  master_done         out  1  one-cycle pulse at end of the frame
//  master_nack_err     out  1  slave NACK seen; held until the next accepted start
// BEHAVIOUR
//  Reset values: scl=1, sda_en=0, mux_select=00, addrslave=0, dataslave=0,
//   demux_select=0, ack_sel=0, rdata=0, busy=0, done=0, nack_err=0; FSM=IDLE.
//  Timing: divider counter 0..CLK_DIV-1 drives phase_tick; SCL toggles on each tick.
//   Bit slot: SCL low phase, then SCL high phase. SDA changes only mid-low.
//   Sampling (slave ACK, read data) occurs on the tick that ends the SCL-high phase.
//  FSM states and transitions:
//   IDLE:  scl=1, sda_en=0. On master_start: latch inputs, clear nack_err, go to START.
//   START: sda_en=1, mux=00 (SDA low while SCL high). Hold 1 half-period, then go to ADDR.
//   ADDR:  8 bit slots, mux=01. Shift register {addr, rw}, MSB first. Go to SACK1.
//   SACK1: sda_en=0, demux_select=0, sample master_ack.
//          1 -> set nack_err, go to STOP. 0 -> go to DATA.
//   DATA (write): mux=10, sda_en=1. 8 slots, then go to SACK2.
//   DATA (read):  sda_en=0, demux_select=1. Shift master_slavedata in MSB first, then go to MACK.
//   SACK2: same as SACK1; a NACK sets nack_err; always go to STOP.
//   MACK:  sda_en=1, mux=11, ack_sel = ~last_latched. Go to STOP.
//   STOP:  mux=00 with SCL low, then SCL high, then release SDA (sda_en=0).
//          Go to DONE.
//   DONE:  master_done=1 for 1 cycle, rdata updated (read only), busy=0. Go to IDLE.
//  master_start while busy is ignored; no queueing.
//  Bit counter is 3 bits and wraps 7->0 at the state exit.
//  Write frame latency: 1 + 2*CLK_DIV*(0.5 + 8 + 1 + 8 + 1 + 1.5) clocks.
//  Async reset mid-frame: all outputs return to reset values immediately; bus released.
// CONFIGURATION
//  MASTER_CLKSTRETCH_EN defined: adds input master_scl_in (1 bit).
//   When the master releases SCL high but master_scl_in==0, the divider
//   freezes until master_scl_in==1 (slave clock stretching). There is no timeout.
//  MASTER_CLKSTRETCH_EN undefined: no master_scl_in port; the divider runs freely.
// TESTING
//  Write: CLK_DIV=4, addr=7'h50, rw=0, wdata=8'hA5, ack=0 on both slots ->
//   addr bits 1010_0000 then data bits 1010_0101 on the mux; done pulses; nack_err=0.
//  Read: addr=7'h3C, rw=1, last=1, slave bits 8'h96 -> rdata=8'h96,
//   ack_sel=0 (NACK) in MACK, demux_select=1 during DATA.
//  Address NACK: master_ack=1 in SACK1 -> no DATA slots, STOP, done, nack_err=1.
//   nack_err clears on the next start.
//  Start while busy: pulse master_start mid-ADDR -> frame unaffected; only one done.
//  Reset mid-DATA: deassert master_rst_n -> scl=1, sda_en=0, busy=0 the same cycle.
//   The next start runs a clean frame.
//  MASTER_CLKSTRETCH_EN: hold master_scl_in=0 for 20 clocks in bit 3 of ADDR ->
//   the frame lengthens by exactly the stretch time; data is still correct.

Source files
------------

// File: rtl/mast_frame_ctrl.sv
// ============================================================================
// mast_frame_ctrl
// ----------------------------------------------------------------------------
// I2C master frame sequencer. Each accepted request runs one single-byte
// transaction: START, 7-bit address + R/W, slave ACK slot, one data byte,
// ACK slot (slave ACK for writes, master ACK/NACK for reads), STOP.
// The block generates SCL and steers the external frame mux, RX demux and
// ACK/NACK mux. It reports the read byte, completion and a slave NACK.
//
// Parameter
//   CLK_DIV              clk cycles per SCL half-period (>= 2)
//
// Ports
//   master_clk           system clock, rising edge
//   master_rst_n         asynchronous active-low reset
//   master_start         one-cycle request, sampled only in IDLE
//   master_rw            0 = write, 1 = read (latched with start)
//   master_addr[6:0]     slave address (latched with start)
//   master_wdata[7:0]    write byte (latched with start)
//   master_last          read only: 1 = send NACK, 0 = send ACK (latched)
//   master_ack           slave ACK bit from demux (0 = ACK)
//   master_slavedata     slave data bit from demux
//   master_scl_in        SCL as seen on the bus (MASTER_CLKSTRETCH_EN only)
//   master_scl           SCL to the bus
//   master_sda_en        1 = drive SDA from mux, 0 = release SDA
//   master_mux_select    00 zero, 01 addr, 10 data, 11 ack
//   master_addrslave     current address/RW bit, MSB first
//   master_dataslave     current write-data bit, MSB first
//   master_demux_select  0 = SDA to master_ack, 1 = SDA to master_slavedata
//   master_ack_sel       1 = master sends ACK, 0 = master sends NACK
//   master_rdata[7:0]    read byte, valid while master_done is high
//   master_busy          frame in progress
//   master_done          one-cycle end-of-frame pulse
//   master_nack_err      slave NACK seen, held until next accepted start
//
// Optional feature: define MASTER_CLKSTRETCH_EN to add master_scl_in and let
// a slave stretch the clock by holding SCL low while the master releases it.
// ============================================================================
module mast_frame_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       master_clk,
    input  logic       master_rst_n,
    input  logic       master_start,
    input  logic       master_rw,
    input  logic [6:0] master_addr,
    input  logic [7:0] master_wdata,
    input  logic       master_last,
    input  logic       master_ack,
    input  logic       master_slavedata,
`ifdef MASTER_CLKSTRETCH_EN
    input  logic       master_scl_in,
`endif
    output logic       master_scl,
    output logic       master_sda_en,
    output logic [1:0] master_mux_select,
    output logic       master_addrslave,
    output logic       master_dataslave,
    output logic       master_demux_select,
    output logic       master_ack_sel,
    output logic [7:0] master_rdata,
    output logic       master_busy,
    output logic       master_done,
    output logic       master_nack_err
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    // SDA is updated halfway through the SCL-low phase
    localparam logic [CW-1:0] DIV_MID  = CW'(CLK_DIV / 2 - 1);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, SACK1, DATA, SACK2, MACK, STOP, DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [7:0]    wdata_lat;
    logic          rw_lat, last_lat;
    logic          scl, nack_err;
    logic [7:0]    rdata;
    logic          sda_en, addrslave, dataslave, demux_select, ack_sel;
    logic [1:0]    mux_select;

    logic          active, freeze, tick, bit_state, slot_end, sda_upd;
    logic          en_d, as_d, ds_d, dmx_d, acks_d;
    logic [1:0]    mux_d;

    // While SCL is released high, a slave holding the line low freezes the divider
`ifdef MASTER_CLKSTRETCH_EN
    assign freeze = scl && !master_scl_in;
`else
    assign freeze = 1'b0;
`endif

    assign active    = (state != IDLE) && (state != DONE);
    assign tick      = active && !freeze && (div_cnt == DIV_LAST);
    assign bit_state = (state == ADDR) || (state == SACK1) || (state == DATA) ||
                       (state == SACK2) || (state == MACK);
    assign slot_end  = tick && bit_state && scl;
    // START and the STOP release must move SDA while SCL is high
    assign sda_upd   = (active && !scl && (div_cnt == DIV_MID)) || (state == START) ||
                       ((state == STOP) && (bit_cnt == 3'd2));

    // State register
    always_ff @(posedge master_clk or negedge master_rst_n) begin
        if (!master_rst_n) state <= IDLE;
        else               state <= state_next;
    end

    // Next state plus the SDA-side values wanted for the current state
    always_comb begin
        state_next = state;
        en_d       = 1'b0;
        mux_d      = 2'b00;
        as_d       = 1'b0;
        ds_d       = 1'b0;
        dmx_d      = 1'b0;
        acks_d     = 1'b0;
        case (state)
            IDLE:  if (master_start) state_next = START;
            START: begin
                en_d = 1'b1;
                if (tick) state_next = ADDR;
            end
            ADDR: begin
                en_d  = 1'b1;
                mux_d = 2'b01;
                as_d  = shreg[7];
                if (slot_end && bit_cnt == 3'd7) state_next = SACK1;
            end
            SACK1: if (slot_end) state_next = master_ack ? STOP : DATA;
            DATA: begin
                if (rw_lat) begin
                    dmx_d = 1'b1;
                end else begin
                    en_d  = 1'b1;
                    mux_d = 2'b10;
                    ds_d  = shreg[7];
                end
                if (slot_end && bit_cnt == 3'd7) state_next = rw_lat ? MACK : SACK2;
            end
            SACK2: if (slot_end) state_next = STOP;
            MACK: begin
                en_d   = 1'b1;
                mux_d  = 2'b11;
                acks_d = ~last_lat;
                if (slot_end) state_next = STOP;
            end
            STOP: begin
                en_d = (bit_cnt != 3'd2);
                if (tick && bit_cnt == 3'd2) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Divider, SCL, bit counter, shifter, latched request and status
    always_ff @(posedge master_clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            div_cnt      <= '0;
            bit_cnt      <= 3'd0;
            shreg        <= 8'h00;
            wdata_lat    <= 8'h00;
            rw_lat       <= 1'b0;
            last_lat     <= 1'b0;
            scl          <= 1'b1;
            nack_err     <= 1'b0;
            rdata        <= 8'h00;
            sda_en       <= 1'b0;
            mux_select   <= 2'b00;
            addrslave    <= 1'b0;
            dataslave    <= 1'b0;
            demux_select <= 1'b0;
            ack_sel      <= 1'b0;
        end else begin
            if (state == IDLE && master_start) begin
                shreg     <= {master_addr, master_rw};
                wdata_lat <= master_wdata;
                rw_lat    <= master_rw;
                last_lat  <= master_last;
                nack_err  <= 1'b0;
                div_cnt   <= '0;
                bit_cnt   <= 3'd0;
                scl       <= 1'b1;
            end

            if (active && !freeze) div_cnt <= tick ? '0 : div_cnt + 1'b1;

            if (tick) begin
                if (state == START) begin
                    scl <= 1'b0;
                end else if (state == STOP) begin
                    // STOP halves: SCL low, SCL high, SCL high with SDA released
                    if (bit_cnt == 3'd0) scl <= 1'b1;
                    bit_cnt <= (bit_cnt == 3'd2) ? 3'd0 : bit_cnt + 3'd1;
                    if (bit_cnt == 3'd2 && rw_lat && !nack_err) rdata <= shreg;
                end else if (!scl) begin
                    scl <= 1'b1;
                end else begin
                    scl <= 1'b0;
                    case (state)
                        ADDR: begin
                            shreg   <= {shreg[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        SACK1: begin
                            if (master_ack) nack_err <= 1'b1;
                            shreg <= rw_lat ? 8'h00 : wdata_lat;
                        end
                        DATA: begin
                            shreg   <= {shreg[6:0], rw_lat & master_slavedata};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        SACK2: if (master_ack) nack_err <= 1'b1;
                        default: ;
                    endcase
                end
            end

            if (sda_upd) begin
                sda_en       <= en_d;
                mux_select   <= mux_d;
                addrslave    <= as_d;
                dataslave    <= ds_d;
                demux_select <= dmx_d;
                ack_sel      <= acks_d;
            end
        end
    end

    assign master_scl          = scl;
    assign master_sda_en       = sda_en;
    assign master_mux_select   = mux_select;
    assign master_addrslave    = addrslave;
    assign master_dataslave    = dataslave;
    assign master_demux_select = demux_select;
    assign master_ack_sel      = ack_sel;
    assign master_rdata        = rdata;
    assign master_nack_err     = nack_err;
    assign master_busy         = active;
    assign master_done         = (state == DONE);

endmodule

// File: tb/tb_mast_frame_ctrl.sv
// ============================================================================
// tb_mast_frame_ctrl
// ----------------------------------------------------------------------------
// Directed bench for mast_frame_ctrl with CLK_DIV = 4. A small slave model
// answers ACK slots and supplies read bits; the SDA-side outputs are recorded
// at every SCL rising edge and compared with hand-computed frame contents.
// With MASTER_CLKSTRETCH_EN defined it also drives master_scl_in.
// ============================================================================
module tb_mast_frame_ctrl;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       master_rst_n;
    logic       master_start;
    logic       master_rw;
    logic [6:0] master_addr;
    logic [7:0] master_wdata;
    logic       master_last;
    logic       master_ack;
    logic       master_slavedata;
`ifdef MASTER_CLKSTRETCH_EN
    logic       master_scl_in;
    int         stretch_at;
`endif
    logic       master_scl;
    logic       master_sda_en;
    logic [1:0] master_mux_select;
    logic       master_addrslave;
    logic       master_dataslave;
    logic       master_demux_select;
    logic       master_ack_sel;
    logic [7:0] master_rdata;
    logic       master_busy;
    logic       master_done;
    logic       master_nack_err;

    int pass_count  = 0;
    int check_count = 0;

    // Per-slot record, indexed by SCL rising edge within the frame
    logic [1:0] cap_mux [0:31];
    logic       cap_en  [0:31];
    logic       cap_as  [0:31];
    logic       cap_ds  [0:31];
    logic       cap_dmx [0:31];
    logic       cap_acks[0:31];
    int         rise_n;
    int         frame_cycles;
    int         done_n;
    int         extra_done;
    logic [7:0] done_rdata;
    logic       done_nack;
    logic [7:0] byte_v;

    always #5 clk = ~clk;

    mast_frame_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .master_clk          (clk),
        .master_rst_n        (master_rst_n),
        .master_start        (master_start),
        .master_rw           (master_rw),
        .master_addr         (master_addr),
        .master_wdata        (master_wdata),
        .master_last         (master_last),
        .master_ack          (master_ack),
        .master_slavedata    (master_slavedata),
`ifdef MASTER_CLKSTRETCH_EN
        .master_scl_in       (master_scl_in),
`endif
        .master_scl          (master_scl),
        .master_sda_en       (master_sda_en),
        .master_mux_select   (master_mux_select),
        .master_addrslave    (master_addrslave),
        .master_dataslave    (master_dataslave),
        .master_demux_select (master_demux_select),
        .master_ack_sel      (master_ack_sel),
        .master_rdata        (master_rdata),
        .master_busy         (master_busy),
        .master_done         (master_done),
        .master_nack_err     (master_nack_err)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // Issues one request and follows the frame to its done pulse. The slave
    // answers slot 8 with ack1, slot 17 with ack2 and feeds sbyte in slots 9..16.
    // poke_idx re-pulses start mid-frame; abort_idx pulls reset mid-frame.
    task automatic applyStimulus(input logic rw, input logic [6:0] addr,
                                 input logic [7:0] wdata, input logic last,
                                 input logic ack1, input logic ack2,
                                 input logic [7:0] sbyte,
                                 input int poke_idx, input int abort_idx);
        logic prev_scl;
        logic poke_pending;
        logic aborted;
        @(posedge clk); #1;
        master_rw    = rw;
        master_addr  = addr;
        master_wdata = wdata;
        master_last  = last;
        master_start = 1'b1;
        @(posedge clk); #1;
        master_start = 1'b0;
        frame_cycles = 1;
        rise_n       = 0;
        done_n       = 0;
        extra_done   = 0;
        done_rdata   = 8'h00;
        done_nack    = 1'b0;
        prev_scl     = master_scl;
        poke_pending = 1'b0;
        aborted      = 1'b0;
        for (int c = 0; c < 4000 && done_n == 0 && !aborted; c++) begin
            @(posedge clk); #1;
            frame_cycles++;
            if (poke_pending) begin
                master_start = 1'b0;
                poke_pending = 1'b0;
            end
            if (master_done) begin
                done_n++;
                done_rdata = master_rdata;
                done_nack  = master_nack_err;
            end
            if (master_scl && !prev_scl) begin
                if (rise_n < 32) begin
                    cap_mux[rise_n]  = master_mux_select;
                    cap_en[rise_n]   = master_sda_en;
                    cap_as[rise_n]   = master_addrslave;
                    cap_ds[rise_n]   = master_dataslave;
                    cap_dmx[rise_n]  = master_demux_select;
                    cap_acks[rise_n] = master_ack_sel;
                end
                if (rise_n == 8) master_ack = ack1;
                if (rise_n >= 9 && rise_n <= 16) master_slavedata = sbyte[16 - rise_n];
                if (rise_n == 17) master_ack = ack2;
                if (rise_n == poke_idx) begin
                    master_addr  = 7'h7F;
                    master_start = 1'b1;
                    poke_pending = 1'b1;
                end
`ifdef MASTER_CLKSTRETCH_EN
                if (rise_n == stretch_at) begin
                    master_scl_in = 1'b0;
                    repeat (20) @(posedge clk);
                    #1;
                    master_scl_in = 1'b1;
                    frame_cycles += 20;
                end
`endif
                if (rise_n == abort_idx) begin
                    master_rst_n = 1'b0;
                    #1;
                    checkOutput("abort_scl", master_scl, 1);
                    checkOutput("abort_sda_en", master_sda_en, 0);
                    checkOutput("abort_busy", master_busy, 0);
                    checkOutput("abort_mux", master_mux_select, 0);
                    @(posedge clk); #1;
                    master_rst_n = 1'b1;
                    aborted = 1'b1;
                end
                rise_n++;
            end
            prev_scl = master_scl;
        end
        if (!aborted) begin
            repeat (10) begin
                @(posedge clk); #1;
                if (master_done) extra_done++;
            end
        end
        master_ack       = 1'b0;
        master_slavedata = 1'b0;
    endtask

    function automatic logic [7:0] addrBits();
        logic [7:0] b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], cap_as[i]};
        return b;
    endfunction

    function automatic logic [7:0] dataBits();
        logic [7:0] b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], cap_ds[9 + i]};
        return b;
    endfunction

    initial begin
        master_rst_n     = 1'b0;
        master_start     = 1'b0;
        master_rw        = 1'b0;
        master_addr      = 7'h00;
        master_wdata     = 8'h00;
        master_last      = 1'b0;
        master_ack       = 1'b0;
        master_slavedata = 1'b0;
`ifdef MASTER_CLKSTRETCH_EN
        master_scl_in    = 1'b1;
        stretch_at       = -1;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_scl", master_scl, 1);
        checkOutput("rst_sda_en", master_sda_en, 0);
        checkOutput("rst_mux", master_mux_select, 0);
        checkOutput("rst_demux", master_demux_select, 0);
        checkOutput("rst_ack_sel", master_ack_sel, 0);
        checkOutput("rst_rdata", master_rdata, 0);
        checkOutput("rst_busy", master_busy, 0);
        checkOutput("rst_done", master_done, 0);
        checkOutput("rst_nack", master_nack_err, 0);
        master_rst_n = 1'b1;

        $display("[TB] write 0x50 <- 0xA5");
        applyStimulus(1'b0, 7'h50, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, -1, -1);
        checkOutput("wr_addr_bits", addrBits(), 8'hA0);
        checkOutput("wr_addr_mux0", cap_mux[0], 1);
        checkOutput("wr_addr_mux7", cap_mux[7], 1);
        checkOutput("wr_addr_en", cap_en[0], 1);
        checkOutput("wr_sack1_en", cap_en[8], 0);
        checkOutput("wr_sack1_demux", cap_dmx[8], 0);
        checkOutput("wr_data_bits", dataBits(), 8'hA5);
        checkOutput("wr_data_mux", cap_mux[9], 2);
        checkOutput("wr_data_en", cap_en[16], 1);
        checkOutput("wr_sack2_en", cap_en[17], 0);
        checkOutput("wr_cycles", frame_cycles, 1 + 2 * CLK_DIV * 20);
        checkOutput("wr_done", done_n, 1);
        checkOutput("wr_extra_done", extra_done, 0);
        checkOutput("wr_nack", done_nack, 0);
        checkOutput("wr_rdata", done_rdata, 8'h00);
        checkOutput("wr_busy_after", master_busy, 0);
        checkOutput("wr_scl_after", master_scl, 1);

        $display("[TB] read 0x3C, last=1, slave 0x96");
        applyStimulus(1'b1, 7'h3C, 8'h00, 1'b1, 1'b0, 1'b0, 8'h96, -1, -1);
        checkOutput("rd_addr_bits", addrBits(), 8'h79);
        checkOutput("rd_rdata", done_rdata, 8'h96);
        checkOutput("rd_data_demux", cap_dmx[9], 1);
        checkOutput("rd_data_en", cap_en[12], 0);
        checkOutput("rd_mack_mux", cap_mux[17], 3);
        checkOutput("rd_mack_en", cap_en[17], 1);
        checkOutput("rd_mack_ack_sel", cap_acks[17], 0);
        checkOutput("rd_cycles", frame_cycles, 1 + 2 * CLK_DIV * 20);
        checkOutput("rd_done", done_n, 1);
        checkOutput("rd_nack", done_nack, 0);

        $display("[TB] read 0x11, last=0, slave 0x5A");
        applyStimulus(1'b1, 7'h11, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, -1, -1);
        checkOutput("rd2_rdata", done_rdata, 8'h5A);
        checkOutput("rd2_mack_ack_sel", cap_acks[17], 1);

        $display("[TB] address NACK");
        applyStimulus(1'b0, 7'h21, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, -1, -1);
        checkOutput("nack_slots", rise_n, 10);
        checkOutput("nack_cycles", frame_cycles, 1 + CLK_DIV * 22);
        checkOutput("nack_done", done_n, 1);
        checkOutput("nack_err_at_done", done_nack, 1);
        checkOutput("nack_err_held", master_nack_err, 1);
        checkOutput("nack_stop_en", cap_en[9], 1);

        $display("[TB] start pulsed while busy");
        applyStimulus(1'b0, 7'h50, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 3, -1);
        checkOutput("busy_addr_bits", addrBits(), 8'hA0);
        checkOutput("busy_data_bits", dataBits(), 8'h3C);
        checkOutput("busy_done", done_n, 1);
        checkOutput("busy_extra_done", extra_done, 0);
        checkOutput("busy_cycles", frame_cycles, 1 + 2 * CLK_DIV * 20);
        checkOutput("busy_nack_cleared", done_nack, 0);
        checkOutput("busy_rdata_kept", done_rdata, 8'h5A);

        $display("[TB] reset during DATA");
        applyStimulus(1'b0, 7'h50, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, -1, 11);
        checkOutput("post_rst_rdata", master_rdata, 8'h00);
        checkOutput("post_rst_busy", master_busy, 0);

        $display("[TB] clean write 0x2B <- 0xC3");
        applyStimulus(1'b0, 7'h2B, 8'hC3, 1'b0, 1'b0, 1'b0, 8'h00, -1, -1);
        checkOutput("clean_addr_bits", addrBits(), 8'h56);
        checkOutput("clean_data_bits", dataBits(), 8'hC3);
        checkOutput("clean_cycles", frame_cycles, 1 + 2 * CLK_DIV * 20);
        checkOutput("clean_done", done_n, 1);

`ifdef MASTER_CLKSTRETCH_EN
        $display("[TB] clock stretch in ADDR bit 3");
        stretch_at = 3;
        applyStimulus(1'b0, 7'h50, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, -1, -1);
        stretch_at = -1;
        checkOutput("str_cycles", frame_cycles, 1 + 2 * CLK_DIV * 20 + 20);
        checkOutput("str_addr_bits", addrBits(), 8'hA0);
        checkOutput("str_data_bits", dataBits(), 8'hA5);
        checkOutput("str_done", done_n, 1);
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
